// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: serial command bridge issuing single-word reads/writes on the native memory bus.
// Define MEM_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYCLES and answer 'T'.
module uart_mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  ERR_BYTE       = 8'h3F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        rx_overrun,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM, RESP} state_t;
    state_t      state;
    logic        is_wr;
    logic        rd_resp;
    logic [1:0]  cnt;
    logic [31:0] rdata;
`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif

    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            rd_resp    <= 1'b0;
            cnt        <= 2'd0;
            rdata      <= 32'd0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wstrb  <= 4'd0;
            rx_overrun <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            // no rx backpressure: bytes arriving while the bus or transmitter is busy are lost
            if (rx_valid && (state == MEM || state == RESP))
                rx_overrun <= 1'b1;
            case (state)
                IDLE: if (rx_valid) begin
                    cnt <= 2'd0;
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        is_wr <= rx_data == 8'h57;
                        state <= ADDR;
                    end else begin
                        rd_resp  <= 1'b0;
                        tx_data  <= ERR_BYTE;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                ADDR: if (rx_valid) begin
                    mem_addr[8*cnt +: 8] <= rx_data;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state     <= is_wr ? DATA : MEM;
                        mem_valid <= !is_wr;
                    end
                end
                DATA: if (rx_valid) begin
                    mem_wdata[8*cnt +: 8] <= rx_data;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state     <= MEM;
                        mem_valid <= 1'b1;
                        mem_wstrb <= 4'hF;
                    end
                end
                MEM: if (mem_ready) begin
                    mem_valid <= 1'b0;
                    mem_wstrb <= 4'd0;
                    rdata     <= mem_rdata;
                    rd_resp   <= !is_wr;
                    tx_data   <= is_wr ? ACK_BYTE : mem_rdata[7:0];
                    tx_valid  <= 1'b1;
                    cnt       <= 2'd0;
                    state     <= RESP;
`ifdef MEM_TIMEOUT_EN
                    tcnt      <= '0;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    mem_valid <= 1'b0;
                    mem_wstrb <= 4'd0;
                    rd_resp   <= 1'b0;
                    tx_data   <= 8'h54;
                    tx_valid  <= 1'b1;
                    state     <= RESP;
                    tcnt      <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
`endif
                end
                RESP: if (tx_ready) begin
                    if (rd_resp && cnt != 2'd3) begin
                        cnt     <= cnt + 2'd1;
                        tx_data <= rdata[8*(2'(cnt + 2'd1)) +: 8];
                    end else begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: directed vectors for uart_mem_bridge with a hand-driven memory slave and throttled transmitter.
module tb_uart_mem_bridge;
    logic        clk = 0;
    logic        reset_n = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_valid = 0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 0;
    logic        mem_valid;
    logic        mem_ready = 0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 0;
    logic        rx_overrun;
    logic        busy;
    int          n_vec = 0;
    int          n_err = 0;
    int          txns = 0;

    uart_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_valid && mem_ready) txns++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1;
        @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input bit wr);
        send(op);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
    endtask

    task automatic wait_mem(input string tag);
        for (int i = 0; i < 50 && !mem_valid; i++) @(negedge clk);
        chk(tag, 32'(mem_valid), 1);
    endtask

    task automatic slave_ack(input logic [31:0] d);
        mem_ready = 1;
        mem_rdata = d;
        @(negedge clk);
        mem_ready = 0;
        mem_rdata = 0;
        chk("mem_valid_drop", 32'(mem_valid), 0);
    endtask

    // transmitter accepts only on every third cycle; the byte must hold meanwhile
    task automatic get_tx(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
        chk(tag, 32'(tx_data), 32'(exp));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, exp});
        end
        tx_ready = 1;
        @(negedge clk);
        tx_ready = 0;
    endtask

    initial begin
        #12;
        chk("rst_outs", {tx_data, 5'd0, tx_valid, mem_valid, busy, rx_overrun, mem_wstrb},
            32'd0);
        chk("rst_addr", mem_addr, 0);
        reset_n = 1;

        send_cmd(8'h57, 32'h10, 32'h0000FFFF, 1);
        wait_mem("wr_mem_valid");
        chk("wr_addr", mem_addr, 32'h10);
        chk("wr_wdata", mem_wdata, 32'h0000FFFF);
        chk("wr_wstrb", 32'(mem_wstrb), 32'hF);
        @(negedge clk);
        chk("wr_busy", 32'(busy), 1);
        slave_ack(32'hA5A5A5A5);
        get_tx("wr_ack", 8'h4B);
        chk("wr_idle", {30'd0, busy, tx_valid}, 0);
        chk("wr_txns", txns, 1);

        send_cmd(8'h52, 32'h20, 0, 0);
        wait_mem("rd_mem_valid");
        chk("rd_addr", mem_addr, 32'h20);
        chk("rd_wstrb", 32'(mem_wstrb), 0);
        @(negedge clk);
        slave_ack(32'h0000FF00);
        get_tx("rd_b0", 8'h00);
        get_tx("rd_b1", 8'hFF);
        get_tx("rd_b2", 8'h00);
        get_tx("rd_b3", 8'h00);
        chk("rd_idle", {30'd0, busy, tx_valid}, 0);
        chk("rd_txns", txns, 2);

        send(8'h41);
        get_tx("unk_err", 8'h3F);
        chk("unk_txns", txns, 2);
        chk("unk_ovr", 32'(rx_overrun), 0);
        send_cmd(8'h52, 32'h0000ABCD, 0, 0);
        wait_mem("unk_next_mem");
        chk("unk_next_addr", mem_addr, 32'h0000ABCD);
        slave_ack(32'h04030201);
        for (int i = 0; i < 4; i++) get_tx("unk_next_rd", 8'(i + 1));

        send_cmd(8'h52, 32'h30, 0, 0);
        wait_mem("ovr_mem");
        send(8'h55);
        chk("ovr_set", 32'(rx_overrun), 1);
        chk("ovr_addr", mem_addr, 32'h30);
        slave_ack(32'h11223344);
        get_tx("ovr_b0", 8'h44);
        get_tx("ovr_b1", 8'h33);
        get_tx("ovr_b2", 8'h22);
        get_tx("ovr_b3", 8'h11);
        chk("ovr_sticky", {30'd0, rx_overrun, busy}, 32'd2);

        send_cmd(8'h57, 32'h50, 32'h12345678, 1);
        wait_mem("rst_mem");
        #2 reset_n = 0;
        #1;
        chk("rst_async", {28'd0, mem_valid, tx_valid, busy, rx_overrun}, 0);
        @(negedge clk);
        reset_n = 1;
        send_cmd(8'h57, 32'h40, 32'hDEADBEEF, 1);
        wait_mem("post_rst_mem");
        chk("post_rst_addr", mem_addr, 32'h40);
        chk("post_rst_wdata", mem_wdata, 32'hDEADBEEF);
        chk("post_rst_wstrb", 32'(mem_wstrb), 32'hF);
        slave_ack(0);
        get_tx("post_rst_ack", 8'h4B);
        chk("post_rst_idle", 32'(busy), 0);

`ifdef MEM_TIMEOUT_EN
        begin
            int hi = 0;
            send_cmd(8'h52, 32'h60, 0, 0);
            wait_mem("to_mem");
            for (int i = 0; i < 50 && mem_valid; i++) begin
                hi++;
                @(negedge clk);
            end
            chk("to_cycles", hi, 8);
            get_tx("to_byte", 8'h54);
            chk("to_idle", {30'd0, busy, mem_valid}, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Byte-stream command bridge acting as a bus master on the native memory interface, directly upstream of bram_controller.
- Receives command bytes from the UART receiver and issues single-word read/write transactions, so a host can load and inspect BRAM over serial.
- Returns acknowledge and read-data bytes to the UART transmitter.

Parameters:
TIMEOUT_CYCLES, 255, mem_ready wait limit in clk cycles (used only with MEM_TIMEOUT_EN).
ACK_BYTE, 8'h4B, write-complete response ('K').
ERR_BYTE, 8'h3F, unknown-command response ('?').

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  transmitter accepts byte this cycle when high with tx_valid
mem_valid  out  1  transaction request
mem_ready  in  1  slave completion
mem_addr  out  32  byte address
mem_wdata  out  32  write data
mem_wstrb  out  4  4'b1111 write, 4'b0000 read
mem_rdata  in  32  read data, valid when mem_ready high
rx_overrun  out  1  sticky: byte dropped while busy
busy  out  1  high in any state except IDLE

Behaviour:
- Clock is clk; reset is asynchronous, active-low (reset_n). Reset: all outputs 0, state IDLE, byte counter 0, shift registers 0.
- Commands (multi-byte fields little-endian, LSB first):
  - 'W' (8'h57) + 4 addr + 4 data → write, then tx ACK_BYTE.
  - 'R' (8'h52) + 4 addr → read, then tx 4 rdata bytes LSB first.
  - Any other first byte → tx ERR_BYTE, back to IDLE.
- States: IDLE, ADDR, DATA, MEM, RESP.
  - IDLE: rx_valid with 'W'/'R' latches opcode, counter←0 → ADDR; other byte → RESP with ERR_BYTE.
  - ADDR: each rx_valid shifts byte into addr[8*cnt +: 8]; after 4th byte → DATA if 'W', else MEM.
  - DATA: same for wdata; after 4th byte → MEM.
  - MEM: mem_valid=1; addr/wdata/wstrb stable while mem_valid high. On first posedge with mem_ready=1: read captures mem_rdata; mem_valid=0 next cycle → RESP. mem_valid low at least one cycle between transactions.
  - RESP: tx_valid=1, tx_data stable until tx_valid&tx_ready. Read sends 4 bytes (cnt 0..3), others 1 byte → IDLE, tx_valid=0.
- No rx backpressure: rx_valid in MEM or RESP drops the byte and sets rx_overrun (cleared only by reset). ADDR/DATA accept bytes normally.
- No inter-byte timeout: partial commands wait indefinitely.
- mem_addr passed unmodified (no alignment check); slave ignores addr[1:0].
- mem_ready while mem_valid=0 ignored.
- Reset mid-transaction: immediate abort, all outputs 0; no response sent.
- rx_valid and tx handshake in the same cycle are independent.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: counter in MEM increments each cycle; reaching TIMEOUT_CYCLES without mem_ready deasserts mem_valid and sends 8'h54 ('T') instead of normal response.
- Undefined: MEM waits forever; no counter logic.

Test Plan:
- Write: rx 57,10,00,00,00,FF,FF,00,00; slave ready after 2 cycles → one txn addr=0x10, wdata=0x0000FFFF, wstrb=1111; tx 0x4B.
- Read: rx 52,20,00,00,00; slave returns 0x0000FF00 → wstrb=0000, addr=0x20; tx 00,FF,00,00 in order, tx_ready throttled to every 3rd cycle, each byte held stable.
- Unknown: rx 0x41 → no mem_valid; tx 0x3F; next 'R' command processed normally.
- Overrun: rx byte 0x55 while in MEM → dropped, rx_overrun=1, response unchanged, rx_overrun still 1 afterwards.
- Reset: reset_n low while mem_valid=1 → mem_valid, tx_valid, busy go 0 asynchronously; after release, full write command works.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8: mem_ready tied 0 → mem_valid drops after 8 cycles; tx 0x54; busy returns 0.
